// File: rtl/sprite_line_fetch.sv
// sprite_line_fetch: fetches one 64-pixel sprite row into a line buffer during hblank
// and replays it, colour-keyed, aligned to hcount during active video.
module sprite_line_fetch #(
  parameter logic [15:0] TRANSP  = 16'h0000,
  parameter int          COORD_W = 10
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               line_start,
  input  logic [COORD_W-1:0] next_y,
  input  logic [COORD_W-1:0] spr_x,
  input  logic [COORD_W-1:0] spr_y,
  input  logic [COORD_W-1:0] hcount,
  input  logic               de,
  output logic [11:0]        rom_addr,
  input  logic [15:0]        rom_data,
  output logic [15:0]        pix_color,
  output logic               pix_valid,
  output logic               fetch_busy
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_n;
  logic [5:0] col, row;
  logic [COORD_W-1:0] xl, rel_y, c;
  logic [11:0] addr_q;
  logic line_hit, in_range, hit;
  logic [15:0] lbuf [64];
  assign rel_y      = next_y - spr_y;
  assign in_range   = (next_y >= spr_y) && (rel_y < COORD_W'(64));
  assign c          = hcount - xl;
  assign hit        = de && line_hit && (hcount >= xl) && (c < COORD_W'(64));
  assign rom_addr   = (state == FETCH) ? {row, col} : addr_q;
  assign fetch_busy = (state != IDLE);
  // a new request always wins, even mid-fetch
  always_comb begin
    state_n = line_start ? (in_range ? FETCH : IDLE)
            : (state == FETCH) ? ((col == 6'd63) ? DRAIN : FETCH)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q    <= '0;
      pix_color <= '0;
      pix_valid <= 1'b0;
      line_hit  <= 1'b0;
      col       <= '0;
      row       <= '0;
      xl        <= '0;
    end else begin
      addr_q    <= rom_addr;
      pix_color <= hit ? lbuf[c[5:0]] : '0;
      pix_valid <= hit && (lbuf[c[5:0]] != TRANSP);
      if (line_start) begin
        xl       <= spr_x;
        row      <= rel_y[5:0];
        col      <= '0;
        line_hit <= 1'b0;
      end else if (state == FETCH) col <= col + 6'd1;
      else if (state == DRAIN) line_hit <= 1'b1;
    end
  end
  // ROM data lags the address by one cycle, so each write lands one column behind
  always_ff @(posedge clk) begin
    if (state == FETCH && col != 6'd0) lbuf[col - 6'd1] <= rom_data;
    else if (state == DRAIN) lbuf[63] <= rom_data;
  end
endmodule

// File: tb/tb_sprite_line_fetch.sv
// tb_sprite_line_fetch: directed checks of fetch timing, display, clipping and colour key.
module tb_sprite_line_fetch;
  logic clk = 1'b0, rstn = 1'b0, line_start = 1'b0, de = 1'b0;
  logic [9:0] next_y = '0, spr_x = '0, spr_y = '0, hcount = '0;
  logic [11:0] rom_addr;
  logic [15:0] rom_data = '0, pix_color;
  logic pix_valid, fetch_busy;
  logic [15:0] rom_mem [4096];
  logic [15:0] exp_buf [64];
  int passed = 0, total = 0;

  sprite_line_fetch dut (
    .clk(clk), .rstn(rstn), .line_start(line_start), .next_y(next_y),
    .spr_x(spr_x), .spr_y(spr_y), .hcount(hcount), .de(de),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_color(pix_color),
    .pix_valid(pix_valid), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic req(input int y, input int x, input int sy);
    next_y = 10'(y); spr_x = 10'(x); spr_y = 10'(sy); line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  // called right after the request edge: expects 64 FETCH cycles then one DRAIN cycle
  task automatic run_fetch(input int base);
    for (int i = 0; i < 64; i++) begin
      chk("fetch_addr", 16'(rom_addr), 16'(base + i));
      chk("fetch_busy", 16'(fetch_busy), 16'd1);
      tick();
    end
    chk("drain_busy", 16'(fetch_busy), 16'd1);
    tick();
    chk("busy_end", 16'(fetch_busy), 16'd0);
    chk("addr_hold", 16'(rom_addr), 16'(base + 63));
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < 64; i++) exp_buf[i] = 16'(base + i);
  endtask

  task automatic show_line(input int x, input bit hl, input int exp_cnt);
    int cnt;
    logic [15:0] ec;
    logic in;
    cnt = 0;
    for (int h = 0; h < 640; h++) begin
      de = 1'b1; hcount = 10'(h);
      tick();
      in = hl && h >= x && h - x < 64;
      ec = in ? exp_buf[h - x] : 16'h0;
      chk("pix_color", pix_color, ec);
      chk("pix_valid", 16'(pix_valid), 16'(in && ec != 16'h0));
      cnt += int'(pix_valid);
    end
    de = 1'b0; hcount = '0;
    tick();
    chk("valid_count", 16'(cnt), 16'(exp_cnt));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 16'(i);
    rom_mem[12'h20A] = 16'h0000;
    tick(); tick();
    chk("rst_addr", 16'(rom_addr), 16'h0);
    chk("rst_busy", 16'(fetch_busy), 16'd0);
    chk("rst_valid", 16'(pix_valid), 16'd0);
    chk("rst_color", pix_color, 16'h0);
    rstn = 1'b1;
    tick();
    // hit line: row 5
    req(105, 200, 100);
    run_fetch(12'h140);
    fill(12'h140);
    show_line(200, 1'b1, 64);
    // reset mid-fetch discards the line
    req(105, 200, 100);
    repeat (20) tick();
    chk("mid_addr", 16'(rom_addr), 16'h154);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("rst2_busy", 16'(fetch_busy), 16'd0);
    chk("rst2_valid", 16'(pix_valid), 16'd0);
    chk("rst2_addr", 16'(rom_addr), 16'h0);
    show_line(200, 1'b0, 0);
    // establish a known address, then two misses must leave it alone
    req(105, 200, 100);
    run_fetch(12'h140);
    req(99, 200, 100);
    chk("miss_above_busy", 16'(fetch_busy), 16'd0);
    tick();
    chk("miss_above_addr", 16'(rom_addr), 16'h17F);
    show_line(200, 1'b0, 0);
    req(164, 200, 100);
    chk("miss_below_busy", 16'(fetch_busy), 16'd0);
    tick();
    chk("miss_below_addr", 16'(rom_addr), 16'h17F);
    show_line(200, 1'b0, 0);
    // colour key at col 10 of row 8
    req(108, 50, 100);
    run_fetch(12'h200);
    fill(12'h200);
    exp_buf[10] = 16'h0000;
    show_line(50, 1'b1, 63);
    // right-edge clip
    req(105, 600, 100);
    run_fetch(12'h140);
    fill(12'h140);
    show_line(600, 1'b1, 40);
    // re-request mid-fetch restarts at the new row
    req(105, 200, 100);
    repeat (30) tick();
    chk("rereq_mid_addr", 16'(rom_addr), 16'h15E);
    chk("rereq_mid_busy", 16'(fetch_busy), 16'd1);
    req(110, 200, 100);
    run_fetch(12'h280);
    fill(12'h280);
    show_line(200, 1'b1, 64);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
